// File: rtl/asic_poc_ctrl.sv
// asic_poc_ctrl: power-on-control sequencer for the padring poc net.
// Holds poc asserted until both supplies are good and settled, releases it,
// and re-asserts it on supply loss with a sticky fault flag.
// Optional feature macro: ASIC_POC_FAULT_CNT_EN (supply-loss event counter).
module asic_poc_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CW            = 16,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       vdd_ok,
  input  logic       vddio_ok,
  input  logic       fault_clr,
  output logic       poc,
  output logic       io_ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] fault_count
);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StSettle = 3'd1,
    StOn     = 3'd2,
    StFault  = 3'd3
  } state_e;

  localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CntOne     = CW'(1);

  logic [SYNC_STAGES-1:0] r_vdd_sync;
  logic [SYNC_STAGES-1:0] r_vddio_sync;
  logic                   w_vdd_s;
  logic                   w_vddio_s;
  logic                   w_good;

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_poc;
  logic          r_io_ready;
  logic          r_fault;

  // Supply-good synchronizers (raw inputs are asynchronous to clk).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vdd_sync   <= '0;
      r_vddio_sync <= '0;
    end else begin
      r_vdd_sync   <= {r_vdd_sync[SYNC_STAGES-2:0], vdd_ok};
      r_vddio_sync <= {r_vddio_sync[SYNC_STAGES-2:0], vddio_ok};
    end
  end

  assign w_vdd_s   = r_vdd_sync[SYNC_STAGES-1];
  assign w_vddio_s = r_vddio_sync[SYNC_STAGES-1];
  assign w_good    = w_vdd_s & w_vddio_s;

  // Next-state and settle-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StSettle: begin
        if (!w_good || !en) begin
          w_state_next = StOff;
          w_cnt_next   = '0;
        end else if (r_cnt == SettleLast) begin
          w_state_next = StOn;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      StOn: begin
        // Supply loss wins over an orderly shutdown in the same cycle.
        if (!w_good) begin
          w_state_next = StFault;
        end else if (!en) begin
          w_state_next = StOff;
        end
      end
      StFault: begin
        if (fault_clr) begin
          w_state_next = StOff;
        end
      end
      default: begin
        // StOff and any unreachable encoding behave as OFF.
        w_cnt_next = '0;
        if (en && w_good) begin
          w_state_next = StSettle;
        end else begin
          w_state_next = StOff;
        end
      end
    endcase
  end

  // State, counter and registered outputs, all updated on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StOff;
      r_cnt      <= '0;
      r_poc      <= 1'b1;
      r_io_ready <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_poc      <= (w_state_next != StOn);
      r_io_ready <= (w_state_next == StOn);
      r_fault    <= (w_state_next == StFault);
    end
  end

  assign poc      = r_poc;
  assign io_ready = r_io_ready;
  assign fault    = r_fault;
  assign state    = r_state;

`ifdef ASIC_POC_FAULT_CNT_EN
  logic [7:0] r_fault_count;

  // Saturating count of ON->FAULT transitions; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault_count <= 8'd0;
    end else if ((r_state == StOn) && (w_state_next == StFault) &&
                 (r_fault_count != 8'hFF)) begin
      r_fault_count <= r_fault_count + 8'd1;
    end
  end

  assign fault_count = r_fault_count;
`else
  assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_asic_poc_ctrl.sv
// Directed self-checking bench for asic_poc_ctrl (SYNC_STAGES=2, SETTLE_CYCLES=8).
module tb_asic_poc_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       vdd_ok;
  logic       vddio_ok;
  logic       fault_clr;
  logic       poc;
  logic       io_ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] fault_count;

  int checks;
  int errors;
  int ecnt;

  asic_poc_ctrl #(
    .SYNC_STAGES  (2),
    .CW           (16),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .vdd_ok     (vdd_ok),
    .vddio_ok   (vddio_ok),
    .fault_clr  (fault_clr),
    .poc        (poc),
    .io_ready   (io_ready),
    .fault      (fault),
    .state      (state),
    .fault_count(fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // Reset with the given inputs, release on a falling edge; next posedge is edge 1.
  task automatic do_reset(input logic e, input logic v, input logic vio);
    reset     = 1'b1;
    en        = e;
    vdd_ok    = v;
    vddio_ok  = vio;
    fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ecnt  = 0;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (state === tgt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    en        = 1'b0;
    vdd_ok    = 1'b0;
    vddio_ok  = 1'b0;
    fault_clr = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (poc !== 1'b1) begin errors++; $display("FAIL rst_poc got %b exp 1", poc); end
    checks++; if (io_ready !== 1'b0) begin errors++; $display("FAIL rst_io_ready got %b exp 0", io_ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
    checks++;
    if (fault_count !== 8'd0) begin
      errors++; $display("FAIL rst_fault_count got %0d exp 0", fault_count);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] exp_state;
    logic       exp_poc;
    do_reset(1'b1, 1'b1, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_state = (e < 3) ? 3'd0 : (e < 11) ? 3'd1 : 3'd2;
      exp_poc   = (e < 11);
      checks++;
      if (state !== exp_state) begin
        errors++; $display("FAIL pu_state edge %0d got %0d exp %0d", e, state, exp_state);
      end
      checks++;
      if (poc !== exp_poc) begin
        errors++; $display("FAIL pu_poc edge %0d got %b exp %b", e, poc, exp_poc);
      end
      checks++;
      if (io_ready !== ~exp_poc) begin
        errors++; $display("FAIL pu_io_ready edge %0d got %b exp %b", e, io_ready, ~exp_poc);
      end
    end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pu_fault got %b exp 0", fault); end
  endtask

  task automatic test_glitch();
    bit seen_on;
    seen_on = 1'b0;
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (8) step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL gl_settle got %0d exp 1", state); end
    vddio_ok = 1'b0;
    repeat (3) begin
      step();
      if (state === 3'd2) seen_on = 1'b1;
    end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL gl_off got %0d exp 0", state); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL gl_fault got %b exp 0", fault); end
    vddio_ok = 1'b1;
    while (ecnt < 21) begin
      step();
      if (state === 3'd2) seen_on = 1'b1;
    end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL gl_resettle got %0d exp 1", state); end
    checks++; if (poc !== 1'b1) begin errors++; $display("FAIL gl_poc_held got %b exp 1", poc); end
    checks++; if (seen_on !== 1'b0) begin errors++; $display("FAIL gl_early_on got %b exp 0", seen_on); end
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL gl_on got %0d exp 2", state); end
    checks++; if (poc !== 1'b0) begin errors++; $display("FAIL gl_poc_rel got %b exp 0", poc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL gl_fault_end got %b exp 0", fault); end
  endtask

  task automatic test_fault();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (11) step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL ft_on got %0d exp 2", state); end
    vdd_ok = 1'b0;
    repeat (2) step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL ft_sync_lag got %0d exp 2", state); end
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL ft_state got %0d exp 3", state); end
    checks++; if (poc !== 1'b1) begin errors++; $display("FAIL ft_poc got %b exp 1", poc); end
    checks++; if (io_ready !== 1'b0) begin errors++; $display("FAIL ft_io_ready got %b exp 0", io_ready); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ft_fault got %b exp 1", fault); end
    vdd_ok = 1'b1;
    repeat (6) step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL ft_sticky got %0d exp 3", state); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ft_sticky_flag got %b exp 1", fault); end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ft_clr_state got %0d exp 0", state); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ft_clr_fault got %b exp 0", fault); end
    repeat (8) step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ft_reseq_settle got %0d exp 1", state); end
    step();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL ft_reseq_on got %0d exp 2", state); end
    checks++; if (io_ready !== 1'b1) begin errors++; $display("FAIL ft_reseq_io got %b exp 1", io_ready); end
  endtask

  task automatic test_loss_priority();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (11) step();
    vdd_ok = 1'b0;
    repeat (2) step();
    // Synchronized vdd drops for the next edge; drop en for that same edge.
    en = 1'b0;
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pri_state got %0d exp 3", state); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL pri_fault got %b exp 1", fault); end
  endtask

  task automatic test_orderly_off();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (11) step();
    en = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL off_state got %0d exp 0", state); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL off_fault got %b exp 0", fault); end
    checks++; if (poc !== 1'b1) begin errors++; $display("FAIL off_poc got %b exp 1", poc); end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL off_clr_noop got %0d exp 0", state); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (11) step();
    checks++; if (io_ready !== 1'b1) begin errors++; $display("FAIL ar_pre_io got %b exp 1", io_ready); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (poc !== 1'b1) begin errors++; $display("FAIL ar_poc got %b exp 1", poc); end
    checks++; if (io_ready !== 1'b0) begin errors++; $display("FAIL ar_io_ready got %b exp 0", io_ready); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fault_count();
    bit         ok;
    int         timeouts;
    logic [7:0] exp_one;
    logic [7:0] exp_final;
`ifdef ASIC_POC_FAULT_CNT_EN
    exp_one   = 8'd1;
    exp_final = 8'd255;
`else
    exp_one   = 8'd0;
    exp_final = 8'd0;
`endif
    timeouts = 0;
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (11) step();
    for (int i = 0; i < 300; i++) begin
      vdd_ok = 1'b0;
      wait_state(3'd3, 10, ok);
      if (!ok) timeouts++;
      vdd_ok    = 1'b1;
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      wait_state(3'd2, 30, ok);
      if (!ok) timeouts++;
      if (i == 0) begin
        checks++;
        if (fault_count !== exp_one) begin
          errors++; $display("FAIL fc_first got %0d exp %0d", fault_count, exp_one);
        end
      end
    end
    checks++;
    if (timeouts !== 0) begin errors++; $display("FAIL fc_timeouts got %0d exp 0", timeouts); end
    checks++;
    if (fault_count !== exp_final) begin
      errors++; $display("FAIL fc_final got %0d exp %0d", fault_count, exp_final);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ecnt      = 0;
    reset     = 1'b1;
    en        = 1'b0;
    vdd_ok    = 1'b0;
    vddio_ok  = 1'b0;
    fault_clr = 1'b0;
    test_reset();
    test_power_up();
    test_glitch();
    test_fault();
    test_loss_priority();
    test_orderly_off();
    test_async_reset();
    test_fault_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
